// File: rtl/axi_mem_pkg.sv
// ---------------------------------------------------------------------------
// axi_mem_pkg
// Shared definitions for the AXI-Lite memory slave: write/read FSM state
// encodings, AXI response codes and the highest legal start byte address.
// ---------------------------------------------------------------------------
package axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_MEM  = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_MEM  = 2'd1,
    R_RESP = 2'd2
  } r_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // A start address above this would run a 4-byte access off the end of Memory.
  localparam logic [6:0] MAX_ADDR    = 7'd124;

endpackage

// File: rtl/axi_mem_slave.sv
// ---------------------------------------------------------------------------
// axi_mem_slave
// Single-beat AXI-Lite slave in front of a byte-addressed Memory block.
// One write FSM and one read FSM; at most one outstanding transaction each.
//
// Ports
//   CLK, RST                 clock, asynchronous active-high reset
//   AW*/W*/B*                write address / data / response channels
//   AR*/R*                   read address / data channels
//   CS, WE, WADDR, RADDR,    Memory strobes, addresses and write data
//   Mem_in
//   Mem_out, writefinish     Memory read data and write-complete flag
//                            (both change on the falling edge of CLK)
// ---------------------------------------------------------------------------
module axi_mem_slave
  import axi_mem_pkg::*;
#(
  parameter int unsigned            ADDR_W   = 7,
  parameter int unsigned            DATA_W   = 32,
  parameter logic [ADDR_W-1:0]      MAX_ADDR = axi_mem_pkg::MAX_ADDR
) (
  input  logic                  CLK,
  input  logic                  RST,
  // write address
  input  logic [ADDR_W-1:0]     AWADDR,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  // write data
  input  logic [DATA_W-1:0]     WDATA,
  input  logic [DATA_W/8-1:0]   WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  // write response
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  // read address
  input  logic [ADDR_W-1:0]     ARADDR,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  // read data
  output logic [DATA_W-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  // Memory side
  output logic                  CS,
  output logic                  WE,
  output logic [ADDR_W-1:0]     WADDR,
  output logic [ADDR_W-1:0]     RADDR,
  output logic [DATA_W-1:0]     Mem_in,
  input  logic [DATA_W-1:0]     Mem_out,
  input  logic                  writefinish
);

  w_state_e             w_state_q, w_state_d;
  r_state_e             r_state_q, r_state_d;
  logic [ADDR_W-1:0]    waddr_q,   waddr_d;
  logic [DATA_W-1:0]    mem_in_q,  mem_in_d;
  logic [1:0]           bresp_q,   bresp_d;
  logic [ADDR_W-1:0]    raddr_q,   raddr_d;
  logic [DATA_W-1:0]    rdata_q,   rdata_d;
  logic [1:0]           rresp_q,   rresp_d;

  logic                 aw_w_req;
  logic                 w_idle;
  logic                 wr_accept;
  logic                 rd_accept;

  // Arbitration: the read side may only accept while the write FSM is idle
  // and no write is being offered this cycle, so writes win ties and a read
  // can never overlap a memory write.
  always_comb begin
    aw_w_req  = AWVALID && WVALID;
    w_idle    = (w_state_q == W_IDLE);
    wr_accept = w_idle && aw_w_req;
    rd_accept = (r_state_q == R_IDLE) && w_idle && !aw_w_req;
  end

  // Ready outputs are combinational; gating with RST keeps them low while
  // reset is asserted even if a master is driving VALID.
  assign AWREADY = wr_accept && !RST;
  assign WREADY  = wr_accept && !RST;
  assign ARREADY = rd_accept && !RST;

  assign BVALID  = (w_state_q == W_RESP);
  assign BRESP   = bresp_q;
  assign RVALID  = (r_state_q == R_RESP);
  assign RRESP   = rresp_q;
  assign RDATA   = rdata_q;

  assign CS      = (w_state_q == W_MEM) || (r_state_q == R_MEM);
  assign WE      = (w_state_q == W_MEM);
  assign WADDR   = waddr_q;
  assign RADDR   = raddr_q;
  assign Mem_in  = mem_in_q;

  // ------------------------------------------------------------------ write
  always_comb begin
    w_state_d = w_state_q;
    waddr_d   = waddr_q;
    mem_in_d  = mem_in_q;
    bresp_d   = bresp_q;
    case (w_state_q)
      W_IDLE: begin
        if (wr_accept) begin
          if ((AWADDR <= MAX_ADDR) && (WSTRB == '1)) begin
            waddr_d   = AWADDR;
            mem_in_d  = WDATA;
            w_state_d = W_MEM;
          end else begin
            bresp_d   = RESP_SLVERR;
            w_state_d = W_RESP;
          end
        end
      end
      W_MEM: begin
        if (writefinish) begin
          bresp_d   = RESP_OKAY;
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (BREADY) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // ------------------------------------------------------------------- read
  always_comb begin
    r_state_d = r_state_q;
    raddr_d   = raddr_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (rd_accept && ARVALID) begin
          if (ARADDR <= MAX_ADDR) begin
            raddr_d   = ARADDR;
            r_state_d = R_MEM;
          end else begin
            rdata_d   = '0;
            rresp_d   = RESP_SLVERR;
            r_state_d = R_RESP;
          end
        end
      end
      R_MEM: begin
        rdata_d   = Mem_out;
        rresp_d   = RESP_OKAY;
        r_state_d = R_RESP;
      end
      R_RESP: begin
        if (RREADY) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      waddr_q   <= '0;
      mem_in_q  <= '0;
      bresp_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
      rresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      waddr_q   <= waddr_d;
      mem_in_q  <= mem_in_d;
      bresp_q   <= bresp_d;
      raddr_q   <= raddr_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule

// File: tb/tb_axi_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_axi_mem_slave
// Directed bench for axi_mem_slave with a behavioural byte-wide Memory
// (preloaded RAM[n]=n for n=0..60) that reacts on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_axi_mem_slave;

  logic        CLK;
  logic        RST;
  logic [6:0]  AWADDR;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WVALID;
  logic        WREADY;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [6:0]  ARADDR;
  logic        ARVALID;
  logic        ARREADY;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RVALID;
  logic        RREADY;
  logic        CS;
  logic        WE;
  logic [6:0]  WADDR;
  logic [6:0]  RADDR;
  logic [31:0] Mem_in;
  logic [31:0] Mem_out;
  logic        writefinish;

  int          n_cmp;
  int          n_err;
  int          cs_cnt;
  logic [7:0]  mem [0:127];

  axi_mem_slave #(
    .ADDR_W   (7),
    .DATA_W   (32),
    .MAX_ADDR (7'd124)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .AWADDR      (AWADDR),
    .AWVALID     (AWVALID),
    .AWREADY     (AWREADY),
    .WDATA       (WDATA),
    .WSTRB       (WSTRB),
    .WVALID      (WVALID),
    .WREADY      (WREADY),
    .BRESP       (BRESP),
    .BVALID      (BVALID),
    .BREADY      (BREADY),
    .ARADDR      (ARADDR),
    .ARVALID     (ARVALID),
    .ARREADY     (ARREADY),
    .RDATA       (RDATA),
    .RRESP       (RRESP),
    .RVALID      (RVALID),
    .RREADY      (RREADY),
    .CS          (CS),
    .WE          (WE),
    .WADDR       (WADDR),
    .RADDR       (RADDR),
    .Mem_in      (Mem_in),
    .Mem_out     (Mem_out),
    .writefinish (writefinish)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Behavioural Memory: falling-edge write with same-edge completion flag,
  // falling-edge little-endian word read.
  initial begin
    Mem_out     = '0;
    writefinish = 1'b0;
    cs_cnt      = 0;
    for (int i = 0; i < 128; i++) mem[i] = (i <= 60) ? 8'(i) : 8'h00;
    forever begin
      @(negedge CLK);
      if (CS) cs_cnt++;
      if (CS && WE) begin
        for (int k = 0; k < 4; k++) mem[WADDR + 7'(k)] = Mem_in[8*k +: 8];
        writefinish = 1'b1;
      end else begin
        writefinish = 1'b0;
      end
      if (CS && !WE)
        Mem_out = {mem[RADDR + 7'd3], mem[RADDR + 7'd2], mem[RADDR + 7'd1], mem[RADDR]};
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entry/exit time for all tasks is 1 time unit after a rising edge.
  task automatic do_write(input string tag, input logic [6:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic [1:0] exp_resp,
                          input int exp_lat, input int hold);
    int lat;
    int cs0;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    #1;
    lat = 0;
    while (!(AWREADY && WREADY) && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    check_eq({tag, "_awwready"}, {AWREADY, WREADY}, 2'b11);
    cs0 = cs_cnt;
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    lat = 1;
    while (!BVALID && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    check_eq({tag, "_blat"}, lat, exp_lat);
    check_eq({tag, "_bresp"}, BRESP, exp_resp);
    for (int h = 0; h < hold; h++) begin
      AWADDR = 7'h30; WDATA = 32'h55AA55AA; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      @(posedge CLK); #1;
      check_eq({tag, "_bhold"}, {BVALID, BRESP, AWREADY}, {1'b1, exp_resp, 1'b0});
    end
    AWVALID = 1'b0; WVALID = 1'b0; BREADY = 1'b1;
    @(posedge CLK); #1;
    BREADY = 1'b0;
    check_eq({tag, "_bdone"}, BVALID, 1'b0);
    check_eq({tag, "_cs"}, cs_cnt - cs0, (exp_resp == 2'b00) ? 1 : 0);
  endtask

  task automatic do_read(input string tag, input logic [6:0] a, input logic [31:0] exp_data,
                         input logic [1:0] exp_resp, input int exp_lat, input int hold);
    int lat;
    int cs0;
    ARADDR = a; ARVALID = 1'b1;
    #1;
    lat = 0;
    while (!ARREADY && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    check_eq({tag, "_arready"}, ARREADY, 1'b1);
    cs0 = cs_cnt;
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    lat = 1;
    while (!RVALID && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    check_eq({tag, "_rlat"}, lat, exp_lat);
    check_eq({tag, "_rdata"}, RDATA, exp_data);
    check_eq({tag, "_rresp"}, RRESP, exp_resp);
    for (int h = 0; h < hold; h++) begin
      ARADDR = 7'h30; ARVALID = 1'b1;
      @(posedge CLK); #1;
      check_eq({tag, "_rhold"}, {RVALID, RDATA, RRESP, ARREADY}, {1'b1, exp_data, exp_resp, 1'b0});
    end
    ARVALID = 1'b0; RREADY = 1'b1;
    @(posedge CLK); #1;
    RREADY = 1'b0;
    check_eq({tag, "_rdone"}, RVALID, 1'b0);
    check_eq({tag, "_cs"}, cs_cnt - cs0, (exp_resp == 2'b00) ? 1 : 0);
  endtask

  initial begin
    int   lat;
    logic rv_seen;
    n_cmp = 0; n_err = 0;
    RST = 1'b1;
    AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
    ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;

    // Reset: outputs zero, readies held low even with VALIDs offered.
    repeat (2) @(posedge CLK);
    #1;
    AWVALID = 1'b1; WVALID = 1'b1; ARVALID = 1'b1;
    #1;
    check_eq("rst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, CS, WE}, '0);
    check_eq("rst_data", {RDATA, WADDR, RADDR}, '0);
    check_eq("rst_memin", Mem_in, '0);
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;

    // Basic reads, including unaligned and boundary addresses.
    do_read("rd04", 7'h04, 32'h07060504, 2'b00, 2, 0);
    do_read("rd05", 7'h05, 32'h08070605, 2'b00, 2, 0);

    // Write then read back.
    do_write("wr10", 7'h10, 32'hDEADBEEF, 4'hF, 2'b00, 2, 0);
    do_read("rd10", 7'h10, 32'hDEADBEEF, 2'b00, 2, 0);

    // Illegal writes: address past the limit, partial strobe.
    do_write("wr7e", 7'h7E, 32'h12345678, 4'hF, 2'b10, 1, 0);
    do_write("wr20s3", 7'h20, 32'hFFFFFFFF, 4'h3, 2'b10, 1, 0);
    do_read("rd20", 7'h20, 32'h23222120, 2'b00, 2, 0);

    // Address limit: 0x7C legal, 0x7D rejected.
    do_write("wr7c", 7'h7C, 32'h11223344, 4'hF, 2'b00, 2, 0);
    do_read("rd7c", 7'h7C, 32'h11223344, 2'b00, 2, 0);
    do_write("wr7d", 7'h7D, 32'h99999999, 4'hF, 2'b10, 1, 0);
    do_read("rd7d", 7'h7D, 32'h00000000, 2'b10, 1, 0);

    // Simultaneous write and read to the same address: write wins.
    AWADDR = 7'h08; WDATA = 32'hCAFEF00D; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
    ARADDR = 7'h08; ARVALID = 1'b1;
    #1;
    check_eq("sim_ready", {AWREADY, WREADY, ARREADY}, 3'b110);
    @(posedge CLK); #1;
    AWVALID = 1'b0; WVALID = 1'b0;
    check_eq("sim_wmem", {CS, WE, ARREADY}, 3'b110);
    BREADY = 1'b1;
    lat = 1;
    while (!BVALID && lat < 20) begin
      @(posedge CLK); #1; lat++;
    end
    check_eq("sim_blat", lat, 2);
    check_eq("sim_bresp", {BRESP, ARREADY}, 3'b000);
    @(posedge CLK); #1;
    BREADY = 1'b0;
    do_read("sim_rd", 7'h08, 32'hCAFEF00D, 2'b00, 2, 0);

    // Back-pressure on both response channels.
    do_write("wrhold", 7'h14, 32'hA5A5C3C3, 4'hF, 2'b00, 2, 5);
    do_read("rdhold", 7'h14, 32'hA5A5C3C3, 2'b00, 2, 5);
    do_read("rdholderr", 7'h7F, 32'h00000000, 2'b10, 1, 5);

    // Reset while the read FSM is in R_MEM.
    ARADDR = 7'h04; ARVALID = 1'b1;
    #1;
    check_eq("rrst_arready", ARREADY, 1'b1);
    @(posedge CLK); #1;
    ARVALID = 1'b0;
    check_eq("rrst_rmem", {CS, WE}, 2'b10);
    RST = 1'b1;
    #1;
    check_eq("rrst_ctrl", {AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, CS, WE}, '0);
    check_eq("rrst_data", {RDATA, WADDR, RADDR}, '0);
    check_eq("rrst_memin", Mem_in, '0);
    @(posedge CLK); #1;
    RST = 1'b0;
    rv_seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      rv_seen = rv_seen | RVALID;
    end
    check_eq("rrst_norvalid", rv_seen, 1'b0);
    do_read("rd00", 7'h00, 32'h03020100, 2'b00, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_mem_slave.md
AXI_MEM_SLAVE -- requirements
Module: axi_mem_slave

Interface
REQ-001 Parameters SHALL be: ADDR_W, 7, byte-address width into Memory; DATA_W, 32, data width; MAX_ADDR, 7'd124, highest legal start byte address.
REQ-002 Ports SHALL be:
  CLK  in  1  single clock; all FSM state updates on rising edge
  RST  in  1  asynchronous, active-high reset
  AWADDR in 7, AWVALID in 1, AWREADY out 1  write address channel
  WDATA in 32, WSTRB in 4, WVALID in 1, WREADY out 1  write data channel
  BRESP out 2, BVALID out 1, BREADY in 1  write response channel
  ARADDR in 7, ARVALID in 1, ARREADY out 1  read address channel
  RDATA out 32, RRESP out 2, RVALID out 1, RREADY in 1  read data channel
  CS out 1, WE out 1, WADDR out 7, RADDR out 7, Mem_in out 32  to Memory
  Mem_out in 32, writefinish in 1  from Memory (both update on falling edge)
REQ-003 Memory-side ports SHALL connect name-for-name to Memory; no other memory signals exist.

Function
REQ-010 Write FSM states SHALL be W_IDLE, W_MEM, W_RESP; read FSM states SHALL be R_IDLE, R_MEM, R_RESP.
REQ-011 In W_IDLE, AWREADY and WREADY SHALL both be 1 only when AWVALID&&WVALID; AW and W are accepted together in one cycle, never separately.
REQ-012 On write accept: legal (AWADDR<=MAX_ADDR and WSTRB==4'hF) -> latch WADDR/Mem_in, go W_MEM; otherwise -> BRESP=2'b10, go W_RESP, no memory access.
REQ-013 In W_MEM, CS=1 and WE=1; at next rising edge go W_RESP with BRESP=2'b00 if writefinish==1, else remain in W_MEM.
REQ-014 In W_RESP, BVALID=1, BRESP held stable until BVALID&&BREADY, then W_IDLE.
REQ-015 In R_IDLE, ARREADY SHALL be 1 only when write FSM is W_IDLE and !(AWVALID&&WVALID); simultaneous write and read requests: write accepted first.
REQ-016 On read accept: legal (ARADDR<=MAX_ADDR) -> latch RADDR, go R_MEM; otherwise -> RDATA=0, RRESP=2'b10, go R_RESP.
REQ-017 In R_MEM, CS=1, WE=0 for one cycle; at next rising edge RDATA<=Mem_out, RRESP=2'b00, go R_RESP.
REQ-018 In R_RESP, RVALID=1, RDATA/RRESP stable until RVALID&&RREADY, then R_IDLE.
REQ-019 ARREADY SHALL be 0 while write FSM is W_MEM, so reads never overlap a memory write; a read accepted after a write's B handshake returns the new data.
REQ-020 Latency: legal write AW/W accept -> BVALID 2 cycles; legal read AR accept -> RVALID 2 cycles; error responses 1 cycle.
REQ-021 WADDR/RADDR SHALL hold their last value when idle; CS=WE=0 outside W_MEM/R_MEM.
REQ-022 Unaligned legal addresses SHALL be passed through unchanged (Memory handles byte lanes).
REQ-023 At most one outstanding write and one outstanding read; no ID, burst, or pipelining.

Reset
REQ-030 RST=1 SHALL immediately force W_IDLE, R_IDLE and all outputs to 0 (AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA, CS, WE, WADDR, RADDR, Mem_in).
REQ-031 Reset mid-transaction SHALL abort it with no B/R response; a write aborted in W_MEM may or may not have reached Memory.

Structure
REQ-040 Package axi_mem_pkg SHALL hold write/read state encodings, RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and MAX_ADDR.
REQ-041 No sub-module; the two FSMs live in axi_mem_slave and share only the W_IDLE arbitration term.

Verification (Memory preloaded RAM[n]=n, n=0..60)
REQ-050 Read ARADDR=7'h04 -> RVALID 2 cycles after accept, RDATA=32'h07060504, RRESP=00.
REQ-051 Write AWADDR=7'h10, WDATA=32'hDEADBEEF, WSTRB=F -> BRESP=00; then read 7'h10 -> 32'hDEADBEEF.
REQ-052 Write 7'h7E, or WSTRB=4'h3 at 7'h20 -> BRESP=10, CS never asserted; read 7'h20 -> 32'h23222120.
REQ-053 AW/W (7'h08, 32'hCAFEF00D) and AR 7'h08 asserted same cycle -> write accepted first, read returns 32'hCAFEF00D.
REQ-054 BREADY/RREADY held low 5 cycles -> BVALID/RVALID and BRESP/RDATA held stable, no new accept.
REQ-055 RST pulsed while in R_MEM -> all outputs 0 within same cycle, no RVALID; next read 7'h00 -> 32'h03020100.
